// File: rtl/seven_seg_capture_if.sv
// Bundle of the multiplexed seven-segment lines seen by the capture monitor
// together with the frame results it reports back.
// master: the side that drives the anode/segment lines (driver or bench).
// slave : the capture monitor.
interface seven_seg_capture_if;
    logic [3:0]  an;             // {an3,an2,an1,an0}, active-low
    logic [7:0]  seg;            // {a,b,c,d,e,f,g,dp}, active-low
    logic [15:0] digits;         // last complete frame, an3 char in [15:12]
    logic [3:0]  dps;            // decimal point per position, 1 = lit
    logic        frame_valid;    // pulse when digits/dps update
    logic        frame_changed;  // pulse when the new frame differs
    logic        err;            // sticky error flag

    modport master (
        output an, seg,
        input  digits, dps, frame_valid, frame_changed, err
    );

    modport slave (
        input  an, seg,
        output digits, dps, frame_valid, frame_changed, err
    );
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: loopback monitor for a four-digit multiplexed
// seven-segment display. Samples the anode/segment lines, waits for SETTLE
// identical samples per anode activation, decodes the segment pattern back
// to a hex character and publishes a frame once all four positions have
// been captured.
// Optional macro SEVSEG_SYNC_EN: when defined, an/seg pass through a 2-flop
// synchronizer ahead of the sampling register (all latencies grow by 2).
module seven_seg_capture #(
    parameter int unsigned SETTLE = 4   // legal range 1..255
) (
    input  logic           clk,
    input  logic           reset,
    seven_seg_capture_if.slave bus
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLING,
        ST_HELD
    } state_t;

    // ------------------------------------------------------------------
    // Input path: optional synchronizer, then one sampling stage plus a
    // copy of the previous sample for stability comparison.
    // ------------------------------------------------------------------
    logic [11:0] raw_w;

`ifdef SEVSEG_SYNC_EN
    logic [11:0] sync1_q;
    logic [11:0] sync2_q;

    // Two-flop synchronizer; idles at all-ones (blanked display).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {bus.an, bus.seg};
            sync2_q <= sync1_q;
        end
    end

    assign raw_w = sync2_q;
`else
    assign raw_w = {bus.an, bus.seg};
`endif

    logic [11:0] smp_q;
    logic [11:0] prev_q;

    // Sampling stage and its one-cycle-delayed copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_q  <= '1;
            prev_q <= '1;
        end else begin
            smp_q  <= raw_w;
            prev_q <= smp_q;
        end
    end

    logic [3:0] an_s;
    logic [7:0] seg_s;
    assign an_s  = smp_q[11:8];
    assign seg_s = smp_q[7:0];

    // ------------------------------------------------------------------
    // Select classification and segment decode of the current sample.
    // ------------------------------------------------------------------
    logic       sel_valid;
    logic       sel_illegal;
    logic [1:0] sel_pos;

    // One low anode selects a position; all high is blanking; anything
    // else is an illegal overlap.
    always_comb begin
        sel_valid   = 1'b0;
        sel_illegal = 1'b0;
        sel_pos     = 2'd0;
        case (an_s)
            4'b1110: begin sel_valid = 1'b1; sel_pos = 2'd0; end
            4'b1101: begin sel_valid = 1'b1; sel_pos = 2'd1; end
            4'b1011: begin sel_valid = 1'b1; sel_pos = 2'd2; end
            4'b0111: begin sel_valid = 1'b1; sel_pos = 2'd3; end
            4'b1111: sel_illegal = 1'b0;
            default: sel_illegal = 1'b1;
        endcase
    end

    logic       dec_ok;
    logic [3:0] dec_char;
    logic       dec_dp;

    // Active-low a..g back to a hex character; all-off is a legal blank.
    always_comb begin
        dec_ok   = 1'b1;
        dec_char = 4'h0;
        case (seg_s[7:1])
            7'b0000001: dec_char = 4'h0;
            7'b1001111: dec_char = 4'h1;
            7'b0010010: dec_char = 4'h2;
            7'b0000110: dec_char = 4'h3;
            7'b1001100: dec_char = 4'h4;
            7'b0100100: dec_char = 4'h5;
            7'b0100000: dec_char = 4'h6;
            7'b0001111: dec_char = 4'h7;
            7'b0000000: dec_char = 4'h8;
            7'b0000100: dec_char = 4'h9;
            7'b0001000: dec_char = 4'hA;
            7'b1100000: dec_char = 4'hB;
            7'b0110001: dec_char = 4'hC;
            7'b1000010: dec_char = 4'hD;
            7'b0110000: dec_char = 4'hE;
            7'b0111000: dec_char = 4'hF;
            7'b1111111: dec_char = 4'h0;
            default:    dec_ok   = 1'b0;
        endcase
    end

    assign dec_dp = ~seg_s[0];

    // ------------------------------------------------------------------
    // Capture decision.
    // A "fresh" evaluation happens from IDLE, on any change while
    // settling, or when the anode moves away from a held position; it
    // loads the counter with 1. With SETTLE==1 that first sample already
    // satisfies the stability requirement.
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [7:0] cnt_q;

    logic       same_w;
    logic       an_same_w;
    logic       fresh_w;
    logic       cont_cap_w;
    logic       capture_w;
    logic [7:0] cnt_inc_w;

    assign same_w    = (smp_q == prev_q);
    assign an_same_w = (smp_q[11:8] == prev_q[11:8]);
    assign cnt_inc_w = (cnt_q >= SETTLE_C) ? cnt_q : cnt_q + 8'd1;

    // Decide whether this edge starts a new evaluation or captures.
    always_comb begin
        fresh_w    = 1'b0;
        cont_cap_w = 1'b0;
        case (state_q)
            ST_IDLE:     fresh_w = 1'b1;
            ST_SETTLING: begin
                fresh_w    = ~same_w;
                cont_cap_w = same_w && (cnt_inc_w >= SETTLE_C);
            end
            ST_HELD:     fresh_w = ~an_same_w;
            default:     fresh_w = 1'b1;
        endcase
        capture_w = cont_cap_w || (fresh_w && sel_valid && (SETTLE_C <= 8'd1));
    end

    // ------------------------------------------------------------------
    // Staging registers: next values per position.
    // ------------------------------------------------------------------
    logic [3:0][3:0] stage_chr_q, stage_chr_d;
    logic [3:0]      stage_dp_q,  stage_dp_d;
    logic [3:0]      cap_mask_q,  cap_mask_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
        logic hit_w;
        assign hit_w          = capture_w && (sel_pos == 2'(gi));
        assign stage_chr_d[gi] = hit_w ? dec_char : stage_chr_q[gi];
        assign stage_dp_d[gi]  = hit_w ? dec_dp   : stage_dp_q[gi];
        assign cap_mask_d[gi]  = cap_mask_q[gi] | hit_w;
    end

    logic        frame_done_w;
    logic [15:0] frame_digits_w;
    logic [15:0] digits_q;
    logic [3:0]  dps_q;
    logic        frame_valid_q;
    logic        frame_changed_q;
    logic        err_q;
    logic        first_q;

    assign frame_done_w   = (cap_mask_d == 4'b1111);
    assign frame_digits_w = {stage_chr_d[3], stage_chr_d[2],
                             stage_chr_d[1], stage_chr_d[0]};

    // Capture FSM with staging, frame assembly and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 8'd0;
            stage_chr_q     <= '0;
            stage_dp_q      <= '0;
            cap_mask_q      <= '0;
            digits_q        <= '0;
            dps_q           <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            err_q           <= 1'b0;
            first_q         <= 1'b1;
        end else begin
            if (capture_w) begin
                state_q <= ST_HELD;
                cnt_q   <= cnt_inc_w;
            end else if (fresh_w) begin
                state_q <= sel_valid ? ST_SETTLING : ST_IDLE;
                cnt_q   <= 8'd1;
            end else if (state_q == ST_SETTLING) begin
                cnt_q   <= cnt_inc_w;
            end

            stage_chr_q <= stage_chr_d;
            stage_dp_q  <= stage_dp_d;

            err_q <= err_q | sel_illegal | (capture_w & ~dec_ok);

            frame_valid_q   <= frame_done_w;
            frame_changed_q <= 1'b0;
            if (frame_done_w) begin
                cap_mask_q      <= 4'b0000;
                digits_q        <= frame_digits_w;
                dps_q           <= stage_dp_d;
                first_q         <= 1'b0;
                frame_changed_q <= first_q ||
                                   ({frame_digits_w, stage_dp_d} != {digits_q, dps_q});
            end else begin
                cap_mask_q <= cap_mask_d;
            end
        end
    end

    assign bus.digits        = digits_q;
    assign bus.dps           = dps_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_changed = frame_changed_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture (SETTLE=4): table of whole frames plus
// hand-written sequences for short holds, glitches, errors and resets.
module tb_seven_seg_capture;

    localparam int SETTLE = 4;
`ifdef SEVSEG_SYNC_EN
    localparam int LAT = SETTLE + 3;
`else
    localparam int LAT = SETTLE + 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seven_seg_capture_if bus();

    seven_seg_capture #(.SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Frame monitor: counts pulses and records the published frame.
    int          fv_cnt = 0;
    logic [15:0] mon_digits = '0;
    logic [3:0]  mon_dps = '0;
    logic        mon_changed = 1'b0;
    logic        fv_prev = 1'b0;
    int          consec = 0;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            fv_cnt      = fv_cnt + 1;
            mon_digits  = bus.digits;
            mon_dps     = bus.dps;
            mon_changed = bus.frame_changed;
            if (fv_prev) consec = consec + 1;
        end
        fv_prev = (bus.frame_valid === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Active-low a..g pattern for a hex character.
    function automatic logic [6:0] enc(input logic [3:0] h);
        case (h)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int pos);
        logic [3:0] one;
        one = 4'b0001;
        an_of = ~(one << pos);
    endfunction

    // Inputs change just after a rising edge and hold for n cycles.
    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int n);
        bus.an  = an;
        bus.seg = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pos(input int pos, input logic [6:0] pat, input logic dp, input int n);
        apply(an_of(pos), {pat, ~dp}, n);
    endtask

    task automatic drive_frame(input logic [6:0] p0, input logic [6:0] p1,
                               input logic [6:0] p2, input logic [6:0] p3,
                               input logic [3:0] dp, input bit rev);
        logic [6:0] pa [4];
        int pos;
        pa[0] = p0; pa[1] = p1; pa[2] = p2; pa[3] = p3;
        for (int k = 0; k < 4; k++) begin
            pos = rev ? 3 - k : k;
            drive_pos(pos, pa[pos], dp[pos], 8);
        end
        apply(4'hF, 8'hFF, 2);
    endtask

    // Drive a position and count edges until frame_valid (bounded).
    task automatic measure(input int pos, input logic [6:0] pat, output int lat);
        bus.an  = an_of(pos);
        bus.seg = {pat, 1'b1};
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        apply(4'hF, 8'hFF, 3);
    endtask

    task automatic do_reset();
        bus.an  = 4'hF;
        bus.seg = 8'hFF;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        apply(4'hF, 8'hFF, 2);
    endtask

    typedef struct {
        logic [6:0]  p0, p1, p2, p3;
        logic [3:0]  dp;
        bit          rev;
        logic [15:0] exp_digits;
        logic [3:0]  exp_dps;
        logic        exp_changed;
    } frame_t;

    frame_t tbl [5];
    int     base;
    int     lat;

    initial begin
        tbl[0] = '{enc(4'h0), enc(4'h1), enc(4'h2), enc(4'h3), 4'b1000, 1'b0, 16'h3210, 4'b1000, 1'b1};
        tbl[1] = '{enc(4'h0), enc(4'h1), enc(4'h2), enc(4'h3), 4'b1000, 1'b0, 16'h3210, 4'b1000, 1'b0};
        tbl[2] = '{enc(4'h9), enc(4'h1), enc(4'h2), enc(4'h3), 4'b1000, 1'b0, 16'h3219, 4'b1000, 1'b1};
        tbl[3] = '{enc(4'hA), enc(4'hB), enc(4'hC), enc(4'hD), 4'b0101, 1'b1, 16'hDCBA, 4'b0101, 1'b1};
        tbl[4] = '{enc(4'hE), enc(4'hF), enc(4'h8), 7'b1111111, 4'b0000, 1'b0, 16'h08FE, 4'b0000, 1'b1};

        bus.an  = 4'hF;
        bus.seg = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_digits", 32'(bus.digits), 32'h0);
        check("reset_dps", 32'(bus.dps), 32'h0);
        check("reset_fv", 32'(bus.frame_valid), 32'h0);
        check("reset_fc", 32'(bus.frame_changed), 32'h0);
        check("reset_err", 32'(bus.err), 32'h0);
        reset = 1'b0;
        apply(4'hF, 8'hFF, 2);

        // Whole frames from the table.
        for (int f = 0; f < 5; f++) begin
            base = fv_cnt;
            drive_frame(tbl[f].p0, tbl[f].p1, tbl[f].p2, tbl[f].p3, tbl[f].dp, tbl[f].rev);
            check($sformatf("frame%0d_count", f), 32'(fv_cnt - base), 32'd1);
            check($sformatf("frame%0d_digits", f), 32'(mon_digits), 32'(tbl[f].exp_digits));
            check($sformatf("frame%0d_dps", f), 32'(mon_dps), 32'(tbl[f].exp_dps));
            check($sformatf("frame%0d_changed", f), 32'(mon_changed), 32'(tbl[f].exp_changed));
        end
        check("blank_no_err", 32'(bus.err), 32'h0);

        // Holds shorter than SETTLE never capture.
        base = fv_cnt;
        for (int p = 0; p < 4; p++) drive_pos(p, enc(4'h7), 1'b0, 3);
        apply(4'hF, 8'hFF, 4);
        check("short_hold_no_frame", 32'(fv_cnt - base), 32'd0);

        // Glitch on the last position: latency counts from the last change.
        drive_pos(0, enc(4'h1), 1'b0, 8);
        drive_pos(1, enc(4'h2), 1'b0, 8);
        drive_pos(2, enc(4'h3), 1'b0, 8);
        drive_pos(3, enc(4'h5), 1'b0, 2);
        drive_pos(3, enc(4'h6), 1'b0, 1);
        base = fv_cnt;
        measure(3, enc(4'h5), lat);
        check("glitch_latency", 32'(lat), 32'(LAT));
        check("glitch_digits", 32'(mon_digits), 32'h5321);
        check("glitch_changed", 32'(mon_changed), 32'h1);

        // Same frame without glitch: clean latency, unchanged frame.
        drive_pos(0, enc(4'h1), 1'b0, 8);
        drive_pos(1, enc(4'h2), 1'b0, 8);
        drive_pos(2, enc(4'h3), 1'b0, 8);
        measure(3, enc(4'h5), lat);
        check("clean_latency", 32'(lat), 32'(LAT));
        check("repeat_changed", 32'(mon_changed), 32'h0);

        // Undefined segment pattern sets err; the frame still completes.
        do_reset();
        drive_pos(0, 7'b1010101, 1'b0, 8);
        check("badpat_err", 32'(bus.err), 32'h1);
        base = fv_cnt;
        drive_pos(1, enc(4'h7), 1'b0, 8);
        drive_pos(2, enc(4'h8), 1'b0, 8);
        drive_pos(3, enc(4'h9), 1'b0, 8);
        apply(4'hF, 8'hFF, 2);
        check("badpat_frame", 32'(fv_cnt - base), 32'd1);
        check("badpat_digits", 32'(mon_digits), 32'h9870);
        check("badpat_err_sticky", 32'(bus.err), 32'h1);

        // Illegal anode overlap sets err; later legal frame still works.
        do_reset();
        check("err_cleared", 32'(bus.err), 32'h0);
        apply(4'b1100, {enc(4'h4), 1'b1}, 3);
        apply(4'hF, 8'hFF, 2);
        check("illegal_an_err", 32'(bus.err), 32'h1);
        base = fv_cnt;
        drive_frame(enc(4'h4), enc(4'h4), enc(4'h4), enc(4'h4), 4'b0001, 1'b0);
        check("illegal_frame", 32'(fv_cnt - base), 32'd1);
        check("illegal_digits", 32'(mon_digits), 32'h4444);
        check("illegal_err_sticky", 32'(bus.err), 32'h1);

        // Reset after two captures discards the partial frame.
        do_reset();
        drive_frame(enc(4'h6), enc(4'h6), enc(4'h6), enc(4'h6), 4'b1111, 1'b0);
        drive_pos(0, enc(4'h1), 1'b0, 8);
        drive_pos(1, enc(4'h1), 1'b0, 8);
        bus.an  = 4'hF;
        bus.seg = 8'hFF;
        reset   = 1'b1;
        #1;
        check("midrst_digits", 32'(bus.digits), 32'h0);
        check("midrst_dps", 32'(bus.dps), 32'h0);
        check("midrst_err", 32'(bus.err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(4'hF, 8'hFF, 2);
        base = fv_cnt;
        drive_pos(2, enc(4'h0), 1'b0, 8);
        drive_pos(3, enc(4'h0), 1'b0, 8);
        apply(4'hF, 8'hFF, 2);
        check("midrst_no_frame", 32'(fv_cnt - base), 32'd0);
        drive_frame(enc(4'h0), enc(4'h0), enc(4'h0), enc(4'h0), 4'b0000, 1'b0);
        check("first_frame_count", 32'(fv_cnt - base), 32'd1);
        check("first_frame_digits", 32'(mon_digits), 32'h0);
        check("first_frame_changed", 32'(mon_changed), 32'h1);

        check("no_back_to_back_fv", 32'(consec), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
